spi_slave: RTL

SPI slave (peripheral) endpoint, the responder for the team's `master` SPI block. It sits on the far side of one chip-select line and samples `sclk`, `cs_n` and `mosi` with its own system clock. It shifts received bits MSB-first into `dataOUT` and drives `miso` from a host-loaded transmit byte. All four cpol/cpha modes are selectable at run time and match the mode handling of `master`.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync.sv | 31 +++
 rtl/spi_slave.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default word width and the
// cpol/cpha mode constants common to the master and slave blocks.
package spi_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_e;

    // Mode encoding is {cpol, cpha}.
    typedef enum logic [1:0] {
        MODE_CPOL0_CPHA0 = 2'b00,
        MODE_CPOL0_CPHA1 = 2'b01,
        MODE_CPOL1_CPHA0 = 2'b10,
        MODE_CPOL1_CPHA1 = 2'b11
    } spi_mode_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer bringing one asynchronous SPI pin into the clk
// domain. RESET_VAL selects the level the chain reports while in reset.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    // NOTE: non-blocking assignment so every stage takes the previous stage's old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples sclk/cs_n/mosi on clk, receives MSB-first
// into dataOUT and shifts a host-loaded byte out on miso, all four modes.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] dataIN,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] dataOUT,
    output logic              rx_valid,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_SHIFT = SHIFT;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(sclk), .q(sclk_s)
    );
    // cs chain resets to "selected" so a frame still running across reset
    // cannot produce a falling edge until cs_n has been seen high.
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk(clk), .reset(reset), .d(cs_n), .q(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(mosi), .q(mosi_s)
    );

    logic [1:0]        state_q, state_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              sclk_prev_q, sclk_prev_d;
    logic              cs_prev_q, cs_prev_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              miso_q, miso_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;

    logic              cs_fall, cs_rise;
    logic              sclk_edge, lead_edge, trail_edge;
    logic              sample_edge, shift_edge;
    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-1:0] load_word;

    always_comb begin
        cs_fall     = cs_prev_q & ~cs_s;
        cs_rise     = ~cs_prev_q & cs_s;
        sclk_edge   = sclk_s ^ sclk_prev_q;
        lead_edge   = sclk_edge & (sclk_prev_q == cpol_q);
        trail_edge  = sclk_edge & (sclk_s == cpol_q);
        sample_edge = cpha_q ? trail_edge : lead_edge;
        shift_edge  = cpha_q ? lead_edge : trail_edge;
        rx_word     = {rx_shift_q, mosi_s};
        load_word   = tx_ready_q ? '0 : tx_buf_q;
    end

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path leaves one unassigned (no latch).
        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        tx_buf_d    = tx_buf_q;
        tx_ready_d  = tx_ready_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        cnt_d       = cnt_q;
        miso_d      = miso_q;
        data_out_d  = data_out_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cs_rise) begin
                    miso_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d      = '0;
                    rx_shift_d = '0;
                    tx_ready_d = 1'b1;
                    // cpha=0 needs the MSB on the wire before the first sample edge.
                    if (cpha_q) begin
                        tx_shift_d = load_word;
                    end else begin
                        miso_d     = load_word[DATA_W-1];
                        tx_shift_d = {load_word[DATA_W-2:0], 1'b0};
                    end
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    frame_err_d = (cnt_q != '0);
                    miso_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else if (sample_edge) begin
                    rx_shift_d = rx_word[DATA_W-2:0];
                    if (cnt_q == CNT_LAST) begin
                        data_out_d = rx_word;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge && (cpha_q || cnt_q != '0)) begin
                    // With cpha=0 the shift edge after a word's last sample is
                    // skipped: LOAD has already presented the next MSB.
                    miso_d     = tx_shift_q[DATA_W-1];
                    tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tx_load && tx_ready_q) begin
            tx_buf_d   = dataIN;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            tx_buf_q    <= '0;
            tx_ready_q  <= 1'b1;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            data_out_q  <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            tx_buf_q    <= tx_buf_d;
            tx_ready_q  <= tx_ready_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            data_out_q  <= data_out_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = miso_q;
    assign tx_ready  = tx_ready_q;
    assign dataOUT   = data_out_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule
